// File: rtl/wbxbc_pkg.sv
// wbxbc_pkg: shared FSM encoding and termination priority for the WbXbc fabric slices.
package wbxbc_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
  typedef struct packed {
    logic err;
    logic rty;
    logic ack;
  } term_t;
  function automatic term_t term_pri(input logic ack, input logic err, input logic rty);
    term_t t;
    t.err = err;
    t.rty = rty & ~err;
    t.ack = ack & ~err & ~rty;
    return t;
  endfunction
endpackage

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: two-entry skid buffer; entry0 is the head, entry1 catches a push while the head is stalled.
module wb_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             async_rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             v0_o,
  output logic             v1_nxt_o,
  output logic [1:0]       occ_nxt_o
);
  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic v0_q, v0_d, v1_q, v1_d;
  always_comb begin
    e0_d = e0_q;
    e1_d = e1_q;
    v0_d = v0_q;
    v1_d = v1_q;
    if (flush_i) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (pop_i) begin
      if (v1_q) begin
        e0_d = e1_q;
        e1_d = push_i ? din_i : e1_q;
        v1_d = push_i;
      end else begin
        e0_d = push_i ? din_i : e0_q;
        v0_d = push_i;
      end
    end else if (push_i) begin
      if (v0_q) begin
        e1_d = din_i;
        v1_d = 1'b1;
      end else begin
        e0_d = din_i;
        v0_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      e0_q <= '0;
      e1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end
  assign dout_o    = e0_q;
  assign v0_o      = v0_q;
  assign v1_nxt_o  = v1_d;
  assign occ_nxt_o = {1'b0, v0_d} + {1'b0, v1_d};
endmodule

// File: rtl/wb_itr_slice.sv
// wb_itr_slice: pipelined Wishbone register slice with skid-buffered requests,
// registered terminations and an outstanding-access cap.
module wb_itr_slice
  import wbxbc_pkg::*;
#(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int SEL_WIDTH  = 2,
  parameter int TGA_WIDTH  = 1,
  parameter int TGC_WIDTH  = 1,
  parameter int TGRD_WIDTH = 1,
  parameter int TGWD_WIDTH = 1,
  parameter int MAX_OUT    = 4
) (
  input  logic                  clk_i,
  input  logic                  async_rst_n_i,
  input  logic                  itr_cyc_i,
  input  logic                  itr_stb_i,
  input  logic                  itr_we_i,
  input  logic                  itr_lock_i,
  input  logic [SEL_WIDTH-1:0]  itr_sel_i,
  input  logic [ADR_WIDTH-1:0]  itr_adr_i,
  input  logic [DAT_WIDTH-1:0]  itr_dat_i,
  input  logic [TGA_WIDTH-1:0]  itr_tga_i,
  input  logic [TGC_WIDTH-1:0]  itr_tgc_i,
  input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
  output logic                  itr_ack_o,
  output logic                  itr_err_o,
  output logic                  itr_rty_o,
  output logic                  itr_stall_o,
  output logic [DAT_WIDTH-1:0]  itr_dat_o,
  output logic [TGRD_WIDTH-1:0] itr_tgd_o,
  output logic                  tgt_cyc_o,
  output logic                  tgt_stb_o,
  output logic                  tgt_we_o,
  output logic                  tgt_lock_o,
  output logic [SEL_WIDTH-1:0]  tgt_sel_o,
  output logic [ADR_WIDTH-1:0]  tgt_adr_o,
  output logic [DAT_WIDTH-1:0]  tgt_dat_o,
  output logic [TGA_WIDTH-1:0]  tgt_tga_o,
  output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
  output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  tgt_ack_i,
  input  logic                  tgt_err_i,
  input  logic                  tgt_rty_i,
  input  logic                  tgt_stall_i,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
  input  logic [TGRD_WIDTH-1:0] tgt_tgd_i
);
  localparam int RW = 2 + SEL_WIDTH + ADR_WIDTH + DAT_WIDTH + TGA_WIDTH + TGC_WIDTH + TGWD_WIDTH;
  localparam int CW = $clog2(MAX_OUT + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stall_q, stall_d;
  term_t term_q, term_d;
  logic [DAT_WIDTH-1:0] rdat_q, rdat_d;
  logic [TGRD_WIDTH-1:0] rtgd_q, rtgd_d;
  logic [RW-1:0] req, head;
  logic [1:0] occ_nxt;
  logic [CW:0] tot;
  logic v0, v1_nxt, lock_buf, accept, pop, flush, term_ok;
  assign accept  = itr_cyc_i & itr_stb_i & ~stall_q;
  assign flush   = (state_q == BUSY) & ~itr_cyc_i;
  assign pop     = v0 & ~tgt_stall_i;
  assign term_ok = (tgt_ack_i | tgt_err_i | tgt_rty_i) & (cnt_q != '0) & (state_q == BUSY) & itr_cyc_i;
  assign req = {itr_we_i, itr_lock_i, itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i};
  assign {tgt_we_o, lock_buf, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o} = head;
  wb_skid_buf #(.WIDTH(RW)) u_skid (
    .clk_i        (clk_i),
    .async_rst_n_i(async_rst_n_i),
    .flush_i      (flush),
    .push_i       (accept),
    .pop_i        (pop),
    .din_i        (req),
    .dout_o       (head),
    .v0_o         (v0),
    .v1_nxt_o     (v1_nxt),
    .occ_nxt_o    (occ_nxt)
  );
  always_comb begin
    state_d = itr_cyc_i ? BUSY : IDLE;
    cnt_d   = flush ? '0
            : (pop & ~term_ok & (cnt_q != CW'(MAX_OUT))) ? cnt_q + CW'(1)
            : (term_ok & ~pop) ? cnt_q - CW'(1) : cnt_q;
    // stall looks at next-cycle occupancy so an accept this cycle is already counted
    tot     = (CW+1)'(cnt_d) + (CW+1)'(occ_nxt);
    stall_d = ~flush & (v1_nxt | (tot >= (CW+1)'(MAX_OUT)));
    term_d  = term_ok ? term_pri(tgt_ack_i, tgt_err_i, tgt_rty_i) : '0;
    rdat_d  = term_ok ? tgt_dat_i : rdat_q;
    rtgd_d  = term_ok ? tgt_tgd_i : rtgd_q;
  end
  always_ff @(posedge clk_i or negedge async_rst_n_i) begin
    if (!async_rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
      term_q  <= '0;
      rdat_q  <= '0;
      rtgd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      term_q  <= term_d;
      rdat_q  <= rdat_d;
      rtgd_q  <= rtgd_d;
    end
  end
  assign tgt_cyc_o   = state_q == BUSY;
  assign tgt_stb_o   = v0;
  assign tgt_lock_o  = (v0 & lock_buf) | ((cnt_q != '0) & itr_lock_i & tgt_cyc_o);
  assign itr_stall_o = stall_q;
  assign itr_ack_o   = term_q.ack;
  assign itr_err_o   = term_q.err;
  assign itr_rty_o   = term_q.rty;
  assign itr_dat_o   = rdat_q;
  assign itr_tgd_o   = rtgd_q;
endmodule
